// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared encodings for the pipeline trace buffer: capture FSM states, trigger
// modes and the packed entry width.
package pipeline_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'b00,
    TRIG_PC  = 2'b01,
    TRIG_OP  = 2'b10,
    TRIG_EXT = 2'b11
  } trig_mode_t;

  localparam int OPCODE_W = 5;

  // One entry is {stage_valid, stage_pc, stage_instr} over all stages.
  function automatic int entry_width(input int num_stages, input int pc_width,
                                     input int instr_width);
    return num_stages * (1 + pc_width + instr_width);
  endfunction

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// Pipeline probe bus plus the replay port of the trace buffer.
interface pipeline_trace_buffer_if
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 32
);
  localparam int ENTRY_W = entry_width(NUM_STAGES, PC_WIDTH, INSTR_WIDTH);

  logic [NUM_STAGES*PC_WIDTH-1:0]    stage_pc;
  logic [NUM_STAGES*INSTR_WIDTH-1:0] stage_instr;
  logic [NUM_STAGES-1:0]             stage_valid;

  // Replay handshake: one entry moves on each clock where rd_valid && rd_ready;
  // while rd_valid && !rd_ready the buffer holds rd_data unchanged.
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (
    output stage_pc, stage_instr, stage_valid, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  stage_pc, stage_instr, stage_valid, rd_ready,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/pipeline_trace_buffer_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module pipeline_trace_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 180
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Per-stage pipeline trace capture: ring of samples, programmable trigger,
// POST_TRIG cycles after it, then oldest-first replay over valid/ready.
module pipeline_trace_buffer
  import pipeline_trace_buffer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 64,
  parameter int POST_TRIG   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  pipeline_trace_buffer_if.slave     bus,
  input  logic                       arm,
  input  logic [1:0]                 trig_mode,
  input  logic [PC_WIDTH-1:0]        trig_value,
  input  logic                       trig_ext,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     entry_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = entry_width(NUM_STAGES, PC_WIDTH, INSTR_WIDTH);

  trace_state_t   state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  post_cnt_q, post_cnt_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic               we;
  logic               trig_hit;
  logic               rd_fire;
  logic [AW-1:0]      wr_ptr_inc;
  logic [CW-1:0]      cnt_inc;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign wr_entry = {bus.stage_valid, bus.stage_pc, bus.stage_instr};

  // Immediate mode fires on the first ARMED cycle, so "always in ARMED" is equivalent.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_t'(trig_mode))
      TRIG_IMM: trig_hit = 1'b1;
      TRIG_PC:  trig_hit = bus.stage_valid[0] &&
                           (bus.stage_pc[PC_WIDTH-1:0] == trig_value);
      TRIG_OP:  trig_hit = bus.stage_valid[0] &&
                           (bus.stage_instr[INSTR_WIDTH-1 -: OPCODE_W] ==
                            trig_value[OPCODE_W-1:0]);
      TRIG_EXT: trig_hit = trig_ext;
      default:  trig_hit = 1'b0;
    endcase
  end

  assign wr_ptr_inc   = wr_ptr_q + 1'b1;
  assign cnt_inc      = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
  assign bus.rd_valid = (state_q == ST_DONE) && (cnt_q != '0);
  assign rd_fire      = bus.rd_valid && bus.rd_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_cnt_d = post_cnt_q;
    cnt_d      = cnt_q;
    we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_ARMED;
          cnt_d      = '0;
          post_cnt_d = '0;
        end
      end
      ST_ARMED, ST_POST: begin
        if (arm) begin
          state_d    = ST_ARMED;
          cnt_d      = '0;
          post_cnt_d = '0;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          cnt_d    = cnt_inc;
          if ((state_q == ST_POST) || trig_hit) begin
            post_cnt_d = (state_q == ST_ARMED) ? CW'(1) : post_cnt_q + 1'b1;
            if (post_cnt_d == CW'(POST_TRIG)) begin
              state_d  = ST_DONE;
              // Oldest entry sits entry_count slots behind the next write slot.
              rd_ptr_d = wr_ptr_inc - cnt_inc[AW-1:0];
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end
      ST_DONE: begin
        if (rd_fire) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  pipeline_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign bus.rd_data = bus.rd_valid ? rd_entry : '0;
  assign state       = state_q;
  assign entry_count = cnt_q;

endmodule
